// File: rtl/rename_pkg.sv
// Shared rename-stage constants and types for the physical register free list.
// Checkpoint support is enabled by defining FREE_LIST_CKPT_EN.
package rename_pkg;

   localparam int NUM_PREGS = 64;
   localparam int NUM_AREGS = 32;
   localparam int PREG_W    = $clog2(NUM_PREGS);

   typedef logic [PREG_W-1:0]    preg_t;
   typedef logic [NUM_PREGS-1:0] preg_mask_t;
   typedef logic [PREG_W:0]      cnt_t;

   // Architectural pregs p0..p(NUM_AREGS-1) are mapped out of reset
   localparam preg_mask_t RST_MAP =
      ~((preg_mask_t'(1) << NUM_AREGS) - preg_mask_t'(1));
   localparam cnt_t RST_CNT = cnt_t'(NUM_PREGS - NUM_AREGS);

   function automatic cnt_t popcnt(preg_mask_t m);
      cnt_t c;
      c = '0;
      for (int i = 0; i < NUM_PREGS; i++) c = c + cnt_t'(m[i]);
      return c;
   endfunction

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Rename/commit-side bundle for the physical register free list.
// Checkpoint strobes exist only when FREE_LIST_CKPT_EN is defined.
interface phys_reg_free_list_if;

   logic [1:0]           alloc_req;
   logic                 alloc_grant;
   rename_pkg::preg_t    alloc_preg0;
   rename_pkg::preg_t    alloc_preg1;
   logic [1:0]           free_en;
   rename_pkg::preg_t    free_preg0;
   rename_pkg::preg_t    free_preg1;
   rename_pkg::cnt_t     free_count;
   logic                 double_free_err;

`ifdef FREE_LIST_CKPT_EN
   logic                 ckpt_save;
   logic                 ckpt_restore;

   modport master (
      output alloc_req, free_en, free_preg0, free_preg1,
      output ckpt_save, ckpt_restore,
      input  alloc_grant, alloc_preg0, alloc_preg1,
      input  free_count, double_free_err
   );

   modport slave (
      input  alloc_req, free_en, free_preg0, free_preg1,
      input  ckpt_save, ckpt_restore,
      output alloc_grant, alloc_preg0, alloc_preg1,
      output free_count, double_free_err
   );
`else
   modport master (
      output alloc_req, free_en, free_preg0, free_preg1,
      input  alloc_grant, alloc_preg0, alloc_preg1,
      input  free_count, double_free_err
   );

   modport slave (
      input  alloc_req, free_en, free_preg0, free_preg1,
      output alloc_grant, alloc_preg0, alloc_preg1,
      output free_count, double_free_err
   );
`endif

endinterface

// File: rtl/free_pick2.sv
// Combinational finder for the two lowest set bits of a free mask.
module free_pick2 import rename_pkg::*; (
   input  preg_mask_t mask_i,
   output preg_t      cand0_o,
   output preg_t      cand1_o,
   output logic [1:0] found_o
);

   always_comb begin
      cand0_o = '0;
      cand1_o = '0;
      found_o = 2'd0;
      for (int i = 0; i < NUM_PREGS; i++) begin
         if (mask_i[i]) begin
            if (found_o == 2'd0) begin
               cand0_o = preg_t'(i);
               found_o = 2'd1;
            end else if (found_o == 2'd1) begin
               cand1_o = preg_t'(i);
               found_o = 2'd2;
            end
         end
      end
   end

endmodule

// File: rtl/phys_reg_free_list.sv
// 2-wide physical register free list with free count and double-free detection.
// Defining FREE_LIST_CKPT_EN adds a snapshot map with save/restore.
module phys_reg_free_list import rename_pkg::*; (
   input  logic                 clk,
   input  logic                 rst,
   phys_reg_free_list_if.slave  fl
);

   preg_mask_t fmap_q, fmap_d;
   cnt_t       cnt_q, cnt_d;
   logic       err_q, err_d;

   preg_t      cand0, cand1;
   logic [1:0] found;
   cnt_t       nreq, ngrant, nfree;
   logic       grant, v0, v1, e0, e1, block;
   preg_mask_t alloc_mask, free_mask;

   free_pick2 u_pick (
      .mask_i  (fmap_q),
      .cand0_o (cand0),
      .cand1_o (cand1),
      .found_o (found)
   );

`ifdef FREE_LIST_CKPT_EN
   preg_mask_t smap_q, smap_d;
   assign block = fl.ckpt_restore;
`else
   assign block = 1'b0;
`endif

   assign nreq  = cnt_t'(fl.alloc_req[0]) + cnt_t'(fl.alloc_req[1]);
   assign grant = (cnt_q >= nreq) && !block;

   assign fl.alloc_grant     = grant;
   assign fl.alloc_preg0     = fl.alloc_req[0] ? cand0 : '0;
   assign fl.alloc_preg1     = !fl.alloc_req[1] ? '0 :
                               (fl.alloc_req[0] ? cand1 : cand0);
   assign fl.free_count      = cnt_q;
   assign fl.double_free_err = err_q;

   // A same-cycle duplicate on port 1 is counted once via port 0
   always_comb begin
      v0 = fl.free_en[0] && (fl.free_preg0 != '0) &&
           !fmap_q[fl.free_preg0];
      e0 = fl.free_en[0] && (fl.free_preg0 != '0) &&
           fmap_q[fl.free_preg0];
      v1 = fl.free_en[1] && (fl.free_preg1 != '0) &&
           !fmap_q[fl.free_preg1] &&
           !(v0 && (fl.free_preg1 == fl.free_preg0));
      e1 = fl.free_en[1] && (fl.free_preg1 != '0) &&
           (fmap_q[fl.free_preg1] ||
            (fl.free_en[0] && (fl.free_preg1 == fl.free_preg0)));
   end

   always_comb begin
      alloc_mask = '0;
      free_mask  = '0;
      if (grant && fl.alloc_req[0]) alloc_mask[fl.alloc_preg0] = 1'b1;
      if (grant && fl.alloc_req[1]) alloc_mask[fl.alloc_preg1] = 1'b1;
      if (v0) free_mask[fl.free_preg0] = 1'b1;
      if (v1) free_mask[fl.free_preg1] = 1'b1;
      ngrant = grant ? nreq : '0;
      nfree  = cnt_t'(v0) + cnt_t'(v1);
      fmap_d = (fmap_q & ~alloc_mask) | free_mask;
      cnt_d  = cnt_q - ngrant + nfree;
      err_d  = err_q | e0 | e1;
`ifdef FREE_LIST_CKPT_EN
      smap_d = smap_q | free_mask;
      if (fl.ckpt_restore) begin
         fmap_d = smap_q | free_mask;
         cnt_d  = popcnt(fmap_d);
      end else if (fl.ckpt_save) begin
         smap_d = fmap_d;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fmap_q <= RST_MAP;
         cnt_q  <= RST_CNT;
         err_q  <= 1'b0;
      end else begin
         fmap_q <= fmap_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

`ifdef FREE_LIST_CKPT_EN
   always_ff @(posedge clk) begin
      if (rst) smap_q <= RST_MAP;
      else     smap_q <= smap_d;
   end
`endif

   logic unused_found;
   assign unused_found = ^found;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed self-checking bench for phys_reg_free_list.
// Checkpoint scenario runs only when FREE_LIST_CKPT_EN is defined.
module tb_phys_reg_free_list;
   import rename_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   phys_reg_free_list_if fl();

   phys_reg_free_list dut (
      .clk (clk),
      .rst (rst),
      .fl  (fl)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      fl.alloc_req  = 2'b00;
      fl.free_en    = 2'b00;
      fl.free_preg0 = '0;
      fl.free_preg1 = '0;
`ifdef FREE_LIST_CKPT_EN
      fl.ckpt_save    = 1'b0;
      fl.ckpt_restore = 1'b0;
`endif
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (fl.free_count !== 7'd32) begin
         failures++;
         $display("FAIL reset_count got=%0d exp=32", fl.free_count);
      end
      checks++;
      if (fl.double_free_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_err got=%b exp=0", fl.double_free_err);
      end
      checks++;
      if (fl.alloc_grant !== 1'b1) begin
         failures++;
         $display("FAIL idle_grant got=%b exp=1", fl.alloc_grant);
      end
      tick();
      checks++;
      if (fl.free_count !== 7'd32) begin
         failures++;
         $display("FAIL idle_count got=%0d exp=32", fl.free_count);
      end
   endtask

   task automatic test_alloc_pair();
      do_reset();
      fl.alloc_req = 2'b11;
      #1;
      checks++;
      if (fl.alloc_grant !== 1'b1 || fl.alloc_preg0 !== 6'd32 ||
          fl.alloc_preg1 !== 6'd33) begin
         failures++;
         $display("FAIL pair_alloc got=%b/%0d/%0d exp=1/32/33",
                  fl.alloc_grant, fl.alloc_preg0, fl.alloc_preg1);
      end
      tick();
      fl.alloc_req = 2'b00;
      #1;
      checks++;
      if (fl.free_count !== 7'd30) begin
         failures++;
         $display("FAIL pair_count got=%0d exp=30", fl.free_count);
      end
   endtask

   task automatic test_drain();
      do_reset();
      fl.alloc_req = 2'b11;
      for (int k = 0; k < 16; k++) begin
         #1;
         checks++;
         if (fl.alloc_grant !== 1'b1 ||
             fl.alloc_preg0 !== preg_t'(32 + 2*k) ||
             fl.alloc_preg1 !== preg_t'(33 + 2*k)) begin
            failures++;
            $display("FAIL drain_%0d got=%b/%0d/%0d exp=1/%0d/%0d", k,
                     fl.alloc_grant, fl.alloc_preg0, fl.alloc_preg1,
                     32 + 2*k, 33 + 2*k);
         end
         tick();
      end
      #1;
      checks++;
      if (fl.free_count !== 7'd0 || fl.alloc_grant !== 1'b0) begin
         failures++;
         $display("FAIL drain_empty got=%0d/%b exp=0/0",
                  fl.free_count, fl.alloc_grant);
      end
      tick();
      checks++;
      if (fl.free_count !== 7'd0) begin
         failures++;
         $display("FAIL drain_hold got=%0d exp=0", fl.free_count);
      end
      fl.alloc_req = 2'b00;
   endtask

   // Runs with the list empty after test_drain
   task automatic test_single();
      fl.free_en    = 2'b01;
      fl.free_preg0 = 6'd40;
      tick();
      idle();
      fl.alloc_req = 2'b11;
      #1;
      checks++;
      if (fl.free_count !== 7'd1 || fl.alloc_grant !== 1'b0) begin
         failures++;
         $display("FAIL single_deny got=%0d/%b exp=1/0",
                  fl.free_count, fl.alloc_grant);
      end
      tick();
      fl.alloc_req = 2'b10;
      #1;
      checks++;
      if (fl.alloc_grant !== 1'b1 || fl.alloc_preg1 !== 6'd40 ||
          fl.alloc_preg0 !== 6'd0 || fl.free_count !== 7'd1) begin
         failures++;
         $display("FAIL single_grant got=%b/%0d/%0d/%0d exp=1/0/40/1",
                  fl.alloc_grant, fl.alloc_preg0, fl.alloc_preg1,
                  fl.free_count);
      end
      tick();
      fl.alloc_req = 2'b00;
      #1;
      checks++;
      if (fl.free_count !== 7'd0) begin
         failures++;
         $display("FAIL single_after got=%0d exp=0", fl.free_count);
      end
   endtask

   task automatic test_no_bypass();
      fl.free_en    = 2'b01;
      fl.free_preg0 = 6'd5;
      fl.alloc_req  = 2'b01;
      #1;
      checks++;
      if (fl.alloc_grant !== 1'b0) begin
         failures++;
         $display("FAIL bypass_deny got=%b exp=0", fl.alloc_grant);
      end
      tick();
      fl.free_en = 2'b00;
      #1;
      checks++;
      if (fl.alloc_grant !== 1'b1 || fl.alloc_preg0 !== 6'd5 ||
          fl.free_count !== 7'd1) begin
         failures++;
         $display("FAIL bypass_next got=%b/%0d/%0d exp=1/5/1",
                  fl.alloc_grant, fl.alloc_preg0, fl.free_count);
      end
      fl.alloc_req = 2'b00;
   endtask

   task automatic test_frees();
      do_reset();
      fl.free_en    = 2'b01;
      fl.free_preg0 = 6'd0;
      tick();
      checks++;
      if (fl.free_count !== 7'd32 || fl.double_free_err !== 1'b0) begin
         failures++;
         $display("FAIL free_p0 got=%0d/%b exp=32/0",
                  fl.free_count, fl.double_free_err);
      end
      fl.free_preg0 = 6'd40;
      tick();
      checks++;
      if (fl.free_count !== 7'd32 || fl.double_free_err !== 1'b1) begin
         failures++;
         $display("FAIL dbl_free got=%0d/%b exp=32/1",
                  fl.free_count, fl.double_free_err);
      end
      fl.free_en    = 2'b11;
      fl.free_preg0 = 6'd7;
      fl.free_preg1 = 6'd7;
      tick();
      checks++;
      if (fl.free_count !== 7'd33 || fl.double_free_err !== 1'b1) begin
         failures++;
         $display("FAIL same_port got=%0d/%b exp=33/1",
                  fl.free_count, fl.double_free_err);
      end
      fl.free_en    = 2'b01;
      fl.free_preg0 = 6'd8;
      fl.free_preg1 = 6'd0;
      fl.alloc_req  = 2'b01;
      #1;
      checks++;
      if (fl.alloc_grant !== 1'b1 || fl.alloc_preg0 !== 6'd7) begin
         failures++;
         $display("FAIL mix_alloc got=%b/%0d exp=1/7",
                  fl.alloc_grant, fl.alloc_preg0);
      end
      tick();
      idle();
      fl.alloc_req = 2'b11;
      #1;
      checks++;
      if (fl.free_count !== 7'd33 || fl.alloc_preg0 !== 6'd8 ||
          fl.alloc_preg1 !== 6'd32) begin
         failures++;
         $display("FAIL mix_next got=%0d/%0d/%0d exp=33/8/32",
                  fl.free_count, fl.alloc_preg0, fl.alloc_preg1);
      end
      fl.alloc_req = 2'b00;
      tick();
   endtask

`ifdef FREE_LIST_CKPT_EN
   task automatic test_ckpt();
      do_reset();
      fl.ckpt_save = 1'b1;
      tick();
      fl.ckpt_save = 1'b0;
      fl.alloc_req = 2'b11;
      tick();
      tick();
      fl.alloc_req  = 2'b00;
      fl.free_en    = 2'b01;
      fl.free_preg0 = 6'd3;
      #1;
      checks++;
      if (fl.free_count !== 7'd28) begin
         failures++;
         $display("FAIL ckpt_alloc got=%0d exp=28", fl.free_count);
      end
      tick();
      idle();
      fl.ckpt_restore = 1'b1;
      fl.alloc_req    = 2'b01;
      #1;
      checks++;
      if (fl.alloc_grant !== 1'b0) begin
         failures++;
         $display("FAIL ckpt_block got=%b exp=0", fl.alloc_grant);
      end
      tick();
      idle();
      fl.alloc_req = 2'b11;
      #1;
      checks++;
      if (fl.free_count !== 7'd33 || fl.alloc_preg0 !== 6'd3 ||
          fl.alloc_preg1 !== 6'd32) begin
         failures++;
         $display("FAIL ckpt_restore got=%0d/%0d/%0d exp=33/3/32",
                  fl.free_count, fl.alloc_preg0, fl.alloc_preg1);
      end
      fl.alloc_req = 2'b00;
   endtask
`endif

   initial begin
      rst = 1'b0;
      idle();
      test_reset();
      test_alloc_pair();
      test_drain();
      test_single();
      test_no_bypass();
      test_frees();
`ifdef FREE_LIST_CKPT_EN
      test_ckpt();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
